// File: rtl/sorter_pkg.sv
// Shared state, message and key encodings for the conveyor sorting controller.
package sorter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ENTRY = 2'd1;
    localparam state_t ST_READY = 2'd2;
    localparam state_t ST_DRIVE = 2'd3;

    localparam logic [3:0] MSG_IDLE    = 4'd0;
    localparam logic [3:0] MSG_ENTRY0  = 4'd1;
    localparam logic [3:0] MSG_ENTRYN  = 4'd2;
    localparam logic [3:0] MSG_READY   = 4'd3;
    localparam logic [3:0] MSG_DRIVE   = 4'd4;
    localparam logic [3:0] MSG_BLOCKED = 4'd5;
    localparam logic [3:0] MSG_JAM     = 4'd6;

    localparam logic [4:0] KEY_START  = 5'hA;
    localparam logic [4:0] KEY_CANCEL = 5'hB;

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter; expire is high in the last cycle of a loaded interval.
module pulse_timer #(
    parameter int unsigned PULSE_CYC = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    output logic expire
);
    localparam int unsigned TW = $clog2(PULSE_CYC + 1);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= TW'(PULSE_CYC);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire = (cnt_q == TW'(1));

endmodule

// File: rtl/sorter_ctrl.sv
// Keypad-configured sorting controller: weight digit entry, then timed, sensor-gated lane pulses.
module sorter_ctrl
    import sorter_pkg::*;
#(
    parameter int unsigned NCH       = 2,
    parameter int unsigned NUM_SLOTS = 2,
    parameter int unsigned PULSE_CYC = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             key,
    input  logic                   key_valid,
    input  logic [3:0]             rfid,
    input  logic                   rfid_valid,
    input  logic [NCH-1:0]         sens,
    output logic [NCH-1:0]         mot,
    output logic [3:0]             msg,
    output logic [4*NUM_SLOTS-1:0] weights,
    output logic [CNT_W-1:0]       sort_cnt,
    output logic                   busy
);
    localparam int unsigned IW = $clog2(NUM_SLOTS + 1);

    state_t         state_q, state_d;
    logic [NCH-1:0] mot_q, mot_d, tag_hot;
    logic [3:0]     msg_q, msg_d;
    logic [3:0]     slot_q [NUM_SLOTS];
    logic [3:0]     slot_d [NUM_SLOTS];
    logic [IW-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]     prev_digit;
    logic           t_load, t_clear, t_expire, cancel, is_digit, dup;

    pulse_timer #(
        .PULSE_CYC(PULSE_CYC)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (t_load),
        .clear (t_clear),
        .expire(t_expire)
    );

    // Tags 0 and >NCH decode to all-zero, which marks them invalid.
    always_comb begin
        tag_hot = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rfid == 4'(i + 1)) tag_hot[i] = 1'b1;
        end
    end

    always_comb begin
        prev_digit = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (idx_q == IW'(i + 1)) prev_digit = slot_q[i];
        end
    end

    assign cancel   = key_valid && (key == KEY_CANCEL);
    assign is_digit = key_valid && (key <= 5'd9);
    assign dup      = (idx_q != '0) && (key[3:0] == prev_digit);

    always_comb begin
        state_d = state_q;
        mot_d   = mot_q;
        msg_d   = msg_q;
        slot_d  = slot_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        t_load  = 1'b0;
        t_clear = 1'b0;
        if (cancel) begin
            state_d = ST_IDLE;
            mot_d   = '0;
            msg_d   = MSG_IDLE;
            idx_d   = '0;
            t_clear = 1'b1;
            for (int i = 0; i < NUM_SLOTS; i++) slot_d[i] = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (key_valid && key == KEY_START) begin
                        state_d = ST_ENTRY;
                        idx_d   = '0;
                        msg_d   = MSG_ENTRY0;
                    end
                end
                ST_ENTRY: begin
                    if (is_digit && !dup) begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (idx_q == IW'(i)) slot_d[i] = key[3:0];
                        end
                        idx_d = idx_q + 1'b1;
                        if (idx_q == IW'(NUM_SLOTS - 1)) begin
                            state_d = ST_READY;
                            msg_d   = MSG_READY;
                        end else begin
                            msg_d = MSG_ENTRYN;
                        end
                    end
                end
                ST_READY: begin
                    if (rfid_valid && (tag_hot != '0)) begin
                        if ((tag_hot & sens) != '0) begin
                            state_d = ST_DRIVE;
                            mot_d   = tag_hot;
                            msg_d   = MSG_DRIVE;
                            t_load  = 1'b1;
                        end else begin
                            msg_d = MSG_BLOCKED;
                        end
                    end
                end
                default: begin
                    // mot_q holds the latched lane, so it doubles as the sensor select.
                    if ((mot_q & ~sens) != '0) begin
                        state_d = ST_READY;
                        mot_d   = '0;
                        msg_d   = MSG_JAM;
                        t_clear = 1'b1;
                    end else if (t_expire) begin
                        state_d = ST_READY;
                        mot_d   = '0;
                        msg_d   = MSG_READY;
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mot_q   <= '0;
            msg_q   <= MSG_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
        end else begin
            state_q <= state_d;
            mot_q   <= mot_d;
            msg_q   <= msg_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= slot_d[i];
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_weights
        assign weights[4*g +: 4] = slot_q[g];
    end

    assign mot      = mot_q;
    assign msg      = msg_q;
    assign sort_cnt = cnt_q;
    assign busy     = |mot_q;

endmodule

// File: tb/tb_sorter_ctrl.sv
// Directed plus random stimulus for sorter_ctrl against a behavioural session model.
module tb_sorter_ctrl;
    localparam int NCH = 2;
    localparam int NS  = 2;
    localparam int PC  = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [4:0]     key = '0;
    logic           key_valid = 1'b0;
    logic [3:0]     rfid = '0;
    logic           rfid_valid = 1'b0;
    logic [NCH-1:0] sens = '1;
    logic [NCH-1:0] mot, mot2;
    logic [3:0]     msg, msg2;
    logic [4*NS-1:0] weights, weights2;
    logic [7:0]     sort_cnt;
    logic [1:0]     sort_cnt2;
    logic           busy, busy2;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 entry, 2 ready, 3 drive.
    int m_mode, m_k, m_msg, m_lane, m_left, m_cnt, m_cnt2;
    int m_slots [NS];

    sorter_ctrl #(.NCH(NCH), .NUM_SLOTS(NS), .PULSE_CYC(PC), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .key_valid(key_valid), .rfid(rfid),
        .rfid_valid(rfid_valid), .sens(sens), .mot(mot), .msg(msg), .weights(weights),
        .sort_cnt(sort_cnt), .busy(busy)
    );

    sorter_ctrl #(.NCH(NCH), .NUM_SLOTS(NS), .PULSE_CYC(PC), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .key(key), .key_valid(key_valid), .rfid(rfid),
        .rfid_valid(rfid_valid), .sens(sens), .mot(mot2), .msg(msg2), .weights(weights2),
        .sort_cnt(sort_cnt2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_msg = 0; m_lane = -1; m_left = 0; m_cnt = 0; m_cnt2 = 0;
        for (int i = 0; i < NS; i++) m_slots[i] = 0;
    endtask

    task automatic model_step();
        int kv;
        kv = int'(key);
        if (key_valid && kv == 11) begin
            m_mode = 0; m_lane = -1; m_msg = 0; m_k = 0;
            for (int i = 0; i < NS; i++) m_slots[i] = 0;
        end else if (m_mode == 0) begin
            if (key_valid && kv == 10) begin m_mode = 1; m_k = 0; m_msg = 1; end
        end else if (m_mode == 1) begin
            if (key_valid && kv <= 9 && !(m_k > 0 && kv == m_slots[m_k-1])) begin
                m_slots[m_k] = kv;
                m_k++;
                m_msg = (m_k == NS) ? 3 : 2;
                if (m_k == NS) m_mode = 2;
            end
        end else if (m_mode == 2) begin
            if (rfid_valid && rfid >= 1 && int'(rfid) <= NCH) begin
                if (sens[rfid-1]) begin
                    m_mode = 3; m_lane = int'(rfid) - 1; m_left = PC; m_msg = 4;
                end else begin
                    m_msg = 5;
                end
            end
        end else begin
            if (!sens[m_lane]) begin
                m_mode = 2; m_lane = -1; m_msg = 6;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 2; m_lane = -1; m_msg = 3;
                    if (m_cnt < 255) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [NCH-1:0]  em;
        logic [4*NS-1:0] ew;
        logic [3:0]      d;
        em = '0;
        if (m_lane >= 0) em[m_lane] = 1'b1;
        ew = '0;
        for (int i = 0; i < NS; i++) begin
            d = m_slots[i][3:0];
            ew[4*i +: 4] = d;
        end
        check("mot", 32'(mot), 32'(em));
        check("msg", 32'(msg), 32'(m_msg));
        check("weights", 32'(weights), 32'(ew));
        check("sort_cnt", 32'(sort_cnt), 32'(m_cnt));
        check("busy", 32'(busy), 32'(m_lane >= 0));
        check("sat_cnt", 32'(sort_cnt2), 32'(m_cnt2));
        check("sat_mot", 32'(mot2), 32'(em));
    endtask

    task automatic cycle(input logic kv, input logic [4:0] k, input logic rv,
                         input logic [3:0] r, input logic [NCH-1:0] s);
        key_valid = kv; key = k; rfid_valid = rv; rfid = r; sens = s;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic press(input logic [4:0] k);
        cycle(1'b1, k, 1'b0, 4'd0, '1);
    endtask

    task automatic tag(input logic [3:0] r, input logic [NCH-1:0] s);
        cycle(1'b0, 5'd0, 1'b1, r, s);
    endtask

    task automatic idle(input logic [NCH-1:0] s);
        cycle(1'b0, 5'd0, 1'b0, 4'd0, s);
    endtask

    initial begin
        int hi;
        model_reset();
        #12;
        check("rst_mot", 32'(mot), 32'd0);
        check("rst_msg", 32'(msg), 32'd0);
        check("rst_weights", 32'(weights), 32'd0);
        check("rst_cnt", 32'(sort_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Entry with a duplicate digit.
        press(5'hA); check("entry_msg0", 32'(msg), 32'd1);
        press(5'd3); check("entry_msg1", 32'(msg), 32'd2);
        press(5'd3); check("entry_dup", 32'(msg), 32'd2);
        press(5'd7); check("entry_done", 32'(msg), 32'd3);
        check("weights_73", 32'(weights), 32'h73);

        // Full pulse on lane 0.
        tag(4'd1, 2'b01);
        check("drive_mot", 32'(mot), 32'b01);
        check("drive_msg", 32'(msg), 32'd4);
        hi = 1;
        for (int i = 0; i < 20 && mot != '0; i++) begin
            idle(2'b01);
            if (mot != '0) hi++;
        end
        check("pulse_len", 32'(hi), 32'(PC));
        check("after_msg", 32'(msg), 32'd3);
        check("after_cnt", 32'(sort_cnt), 32'd1);

        // Blocked lane, then invalid tag.
        tag(4'd2, 2'b01); check("blocked_mot", 32'(mot), 32'd0);
        check("blocked_msg", 32'(msg), 32'd5);
        tag(4'd3, 2'b01); check("invalid_msg", 32'(msg), 32'd5);

        // Jam on lane 1 during the third drive cycle.
        tag(4'd2, 2'b11); check("lane1_mot", 32'(mot), 32'b10);
        idle(2'b11); idle(2'b11);
        idle(2'b01);
        check("jam_mot", 32'(mot), 32'd0);
        check("jam_msg", 32'(msg), 32'd6);
        check("jam_cnt", 32'(sort_cnt), 32'd1);

        // Back-to-back: tag right after a pulse ends.
        tag(4'd1, 2'b11);
        for (int i = 0; i < PC; i++) idle(2'b11);
        tag(4'd2, 2'b11); check("b2b_mot", 32'(mot), 32'b10);

        // Cancel together with rfid mid-pulse.
        cycle(1'b1, 5'hB, 1'b1, 4'd1, 2'b11);
        check("cancel_mot", 32'(mot), 32'd0);
        check("cancel_msg", 32'(msg), 32'd0);
        check("cancel_w", 32'(weights), 32'd0);
        check("cancel_cnt", 32'(sort_cnt), 32'd2);
        press(5'hA); check("idle_start", 32'(msg), 32'd1);

        // Asynchronous reset mid-pulse.
        press(5'd1); press(5'd2); tag(4'd1, 2'b11); idle(2'b11);
        #3 rst_n = 1'b0;
        #1 check("async_mot", 32'(mot), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation of the narrow counter.
        press(5'hA); press(5'd4); press(5'd9);
        for (int n = 0; n < 5; n++) begin
            tag(4'd1, 2'b11);
            for (int i = 0; i < PC; i++) idle(2'b11);
        end
        check("sat_3", 32'(sort_cnt2), 32'd3);
        check("wide_5", 32'(sort_cnt), 32'd5);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            logic           kv, rv;
            logic [4:0]     k;
            logic [3:0]     r;
            logic [NCH-1:0] s;
            int             sel;
            kv  = ($urandom_range(0, 99) < 30);
            sel = $urandom_range(0, 99);
            if (sel < 3) k = 5'hB;
            else if (sel < 15) k = 5'hA;
            else if (sel < 20) k = 5'($urandom_range(12, 31));
            else k = 5'($urandom_range(0, 9));
            rv = ($urandom_range(0, 99) < 25);
            r  = 4'($urandom_range(0, 4));
            s  = ($urandom_range(0, 19) == 0) ? NCH'($urandom_range(0, 3)) : '1;
            cycle(kv, k, rv, r, s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sorter_ctrl.md
# sorter_ctrl

Parametrised keypad-configured sorting controller for the conveyor. It collects NUM_SLOTS weight digits from the keypad, then routes tagged items to one of NCH lanes. Each route is a timed motor pulse, gated by a per-lane clear-path sensor, with jam detection and a saturating count of sorted items. It sits between the keypad/RFID front-ends and the motor drivers and message display.

## Interface
- NCH, 2, number of lanes (motor outputs and sensors), 1..15
- NUM_SLOTS, 2, number of weight digits entered per session, 1..8
- PULSE_CYC, 8, motor pulse length in clk cycles, ≥1
- CNT_W, 8, width of sorted-item counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- key  in  5  keypad code (0–9 digits, 0xA start, 0xB cancel, others ignored)
- key_valid  in  1  one-cycle strobe, key valid this cycle
- rfid  in  4  lane tag: value i+1 selects lane i; 0 or >NCH = no/invalid tag
- rfid_valid  in  1  one-cycle strobe, rfid valid this cycle
- sens  in  NCH  sens[i]=1: lane i path clear
- mot  out  NCH  one-hot motor drive, lane i
- msg  out  4  display message code
- weights  out  4*NUM_SLOTS  entered digits, slot k at [4k+3:4k]
- sort_cnt  out  CNT_W  completed sorts, saturating
- busy  out  1  high while a motor pulse is active

## Operation
- States: IDLE, ENTRY, READY, DRIVE.
- Message codes: IDLE 0, ENTRY slot 0 → 1, ENTRY slot >0 → 2, READY 3, DRIVE 4, blocked 5, jam 6.
- Key 0xB (cancel) in any state → IDLE. On cancel: mot=0, all slots cleared to 0, msg=0. sort_cnt is kept.
- IDLE: key 0xA → ENTRY with slot index k=0. All other keys are ignored.
- ENTRY: a digit 0–9 is stored in slot k and k increments. Any other key except 0xB is ignored.
- ENTRY: a digit equal to slot k-1 (k>0) is ignored (duplicate rejection).
- ENTRY: after slot NUM_SLOTS-1 is stored → READY, msg=3.
- READY: non-cancel keys are ignored.
- READY, rfid_valid with valid lane L and sens[L]=1 → DRIVE. On entry: mot=1<<L, msg=4, timer loaded with PULSE_CYC.
- READY, rfid_valid with valid lane L and sens[L]=0 → stay READY, msg=5. msg holds 5 until the next accepted rfid event.
- READY, invalid tag → no change.
- DRIVE: lane L is latched at entry. rfid events are dropped.
- DRIVE: timer decrements each cycle. When it expires → READY with mot=0, msg=3, and sort_cnt incremented if not at its maximum value.
- DRIVE: sens[L]=0 on any cycle → mot=0, msg=6, READY. No count increment.
- Priority within one cycle: cancel > jam > timer expiry > rfid.
- When key_valid and rfid_valid occur together in READY, a cancel key wins. Otherwise the rfid event is processed.

## Timing
- All outputs are registered. The response to a strobe or sensor sampled at edge n is visible after edge n.
- Reset values: state IDLE, mot 0, msg 0, weights 0, sort_cnt 0, busy 0.
- Asserting rst_n low at any time, including mid-pulse, forces mot=0 immediately without waiting for clk.
- mot is high for exactly PULSE_CYC cycles on an uninterrupted pulse. busy equals |mot.
- A jam or cancel detected at edge n drops mot after edge n.
- Back-to-back operation: rfid_valid arriving in the first READY cycle after a pulse is accepted.
- sort_cnt saturates at 2^CNT_W-1 and never wraps.

## Structure
- Package sorter_pkg holds:
  - the state enum;
  - the msg code constants (MSG_IDLE..MSG_JAM);
  - the key constants KEY_START=0xA and KEY_CANCEL=0xB.
- Sub-module pulse_timer: loadable down-counter of width $clog2(PULSE_CYC+1). Ports: load, clear, expire pulse. Instantiated once.
- Slot storage is a NUM_SLOTS×4 register array with an index counter of width $clog2(NUM_SLOTS+1).

## Test plan
- Reset, then keys A,3,3,7 (NUM_SLOTS=2) → msg sequence 1,2,2,3; weights=0x73; state READY.
- READY, rfid=1, sens=2'b01 → mot=2'b01 for exactly 8 cycles, msg=4 then 3, sort_cnt=1.
- READY, rfid=2, sens=2'b01 → mot stays 0, msg=5. Then rfid=3 (invalid) → msg stays 5.
- DRIVE on lane 1, sens[1] dropped at cycle 3 → mot=0 the next cycle, msg=6, sort_cnt unchanged.
- DRIVE, key 0xB together with rfid_valid → mot=0, msg=0, weights=0, state IDLE. rst_n low mid-pulse → mot=0 asynchronously.
- CNT_W=2: five complete sorts → sort_cnt=3 (saturates).
